// File: rtl/mips_mem_loader_pkg.sv
// Shared types and helpers for the MIPS boot loader.
//   loader_state_t : top-level loader FSM states
//   byte_lane()    : picks byte k of a word in the configured endianness
package mips_loader_pkg;

   localparam int unsigned MAX_WORD_W = 64;

   typedef enum logic [2:0] {
      LOAD,
      WRITE,
      RUN,
      DRAIN,
      DONE
   } loader_state_t;

   // Byte k of a (zero-extended) word; k = 0 is the byte for the lowest address.
   function automatic logic [7:0] byte_lane(input logic [MAX_WORD_W-1:0] word,
                                            input int unsigned           k,
                                            input logic                  big_endian,
                                            input int unsigned           bytes);
      int unsigned lane;
      lane = big_endian ? (bytes - 1 - k) : k;
      return 8'(word >> (lane * 8));
   endfunction

endpackage

// File: rtl/mips_mem_loader_if.sv
// Stream, memory write port and core-control signals of the boot loader.
//   master : loader side (drives s_ready, memory write port, cpu_run, last_pc, done, err)
//   slave  : host/memory/core side (drives s_valid, s_data, s_last, pc)
interface mips_mem_loader_if #(
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned NUM_MEMS = 2
);
   logic                s_valid;
   logic                s_ready;
   logic [WORD_W-1:0]   s_data;
   logic                s_last;
   logic [NUM_MEMS-1:0] mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [7:0]          mem_wdata;
   logic                cpu_run;
   logic [ADDR_W-1:0]   pc;
   logic [ADDR_W-1:0]   last_pc;
   logic                done;
   logic                err;

   modport master (
      input  s_valid, s_data, s_last, pc,
      output s_ready, mem_we, mem_addr, mem_wdata, cpu_run, last_pc, done, err
   );

   modport slave (
      output s_valid, s_data, s_last, pc,
      input  s_ready, mem_we, mem_addr, mem_wdata, cpu_run, last_pc, done, err
   );
endinterface

// File: rtl/mips_mem_loader_word_byte_serializer.sv
// Latches one stream word and presents its bytes, lane-ordered, one per cycle.
//   clk, rst     : clock, async active-high reset
//   load         : capture word; byte 0 is on byte_out the next cycle
//   word         : word to serialise
//   busy         : a byte of the latched word is on byte_out
//   byte_out     : registered byte for the current cycle
//   last_byte_c  : byte_out holds the final byte of the word
module word_byte_serializer
   import mips_loader_pkg::*;
#(
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned BIG_ENDIAN = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] word,
   output logic              busy,
   output logic [7:0]        byte_out,
   output logic              last_byte_c
);
   localparam int unsigned BYTES = WORD_W / 8;
   localparam int unsigned IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic        BE    = (BIG_ENDIAN != 0);

   logic [WORD_W-1:0] hold;
   logic [IW-1:0]     idx;

   assign last_byte_c = busy && (idx == IW'(BYTES - 1));

   // idx tracks which byte is currently on byte_out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold     <= '0;
         idx      <= '0;
         busy     <= 1'b0;
         byte_out <= '0;
      end else if (load) begin
         hold     <= word;
         idx      <= '0;
         busy     <= 1'b1;
         byte_out <= byte_lane(MAX_WORD_W'(word), 0, BE, BYTES);
      end else if (busy) begin
         if (last_byte_c) begin
            busy <= 1'b0;
         end else begin
            idx      <= idx + IW'(1);
            byte_out <= byte_lane(MAX_WORD_W'(hold), 32'(idx) + 32'd1, BE, BYTES);
         end
      end
   end

endmodule

// File: rtl/mips_mem_loader.sv
// Boot loader: streams words byte-serially into NUM_MEMS memories, then releases
// the core and raises done DRAIN_CYC+1 edges after pc reaches the last loaded word.
//   clk, rst : clock, async active-high reset
//   bus      : stream in (s_valid/s_ready/s_data/s_last), memory write port
//              (mem_we/mem_addr/mem_wdata), core control (cpu_run, pc, last_pc),
//              status (done, err)
module mips_mem_loader
   import mips_loader_pkg::*;
#(
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned NUM_MEMS   = 2,
   parameter int unsigned BIG_ENDIAN = 0,
   parameter int unsigned DRAIN_CYC  = 2
) (
   input  logic              clk,
   input  logic              rst,
   mips_mem_loader_if.master bus
);
   localparam int unsigned BYTES      = WORD_W / 8;
   localparam int unsigned BW         = ADDR_W + 1;  // base may sit one past the top
   localparam int unsigned OW         = ADDR_W + 2;
   localparam int unsigned SW         = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
   localparam int unsigned DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam int unsigned DRAIN_LAST = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;
   localparam logic [SW-1:0] LAST_SEL = SW'(NUM_MEMS - 1);
   localparam logic [OW-1:0] ADDR_TOP = OW'((1 << ADDR_W) - 1);

   loader_state_t state, state_d;
   logic [SW-1:0] sel;
   logic [BW-1:0] base;
   logic          lat_last;
   logic          lat_ovf;
   logic [DW-1:0] drain_cnt;
   logic          accept_c;
   logic          ovf_c;
   logic          ser_busy;
   logic          ser_last_c;
   logic [7:0]    ser_byte;
   logic          s_ready_d;
   logic          cpu_run_d;
   logic          done_d;

   assign accept_c = (state == LOAD) && bus.s_valid && !ser_busy;
   assign ovf_c    = (OW'(base) + OW'(BYTES - 1)) > ADDR_TOP;

   word_byte_serializer #(
      .WORD_W     (WORD_W),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_ser (
      .clk         (clk),
      .rst         (rst),
      .load        (accept_c),
      .word        (bus.s_data),
      .busy        (ser_busy),
      .byte_out    (ser_byte),
      .last_byte_c (ser_last_c)
   );

   assign bus.mem_wdata = ser_byte;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         LOAD:  if (accept_c) state_d = WRITE;
         WRITE: if (ser_last_c) state_d = (lat_last && (sel == LAST_SEL)) ? RUN : LOAD;
         RUN:   if (bus.pc == bus.last_pc) state_d = (DRAIN_CYC == 0) ? DONE : DRAIN;
         DRAIN: if (drain_cnt == DW'(DRAIN_LAST)) state_d = DONE;
         DONE:  state_d = DONE;
         default: state_d = LOAD;
      endcase
   end

   // Status outputs follow the next state so their registers line up with it
   always_comb begin
      s_ready_d = 1'b0;
      cpu_run_d = 1'b0;
      done_d    = 1'b0;
      case (state_d)
         LOAD:    s_ready_d = 1'b1;
         RUN,
         DRAIN:   cpu_run_d = 1'b1;
         DONE: begin
            cpu_run_d = 1'b1;
            done_d    = 1'b1;
         end
         default: ;
      endcase
   end

   // Registered outputs, segment/address counters and drain counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel          <= '0;
         base         <= '0;
         lat_last     <= 1'b0;
         lat_ovf      <= 1'b0;
         drain_cnt    <= '0;
         bus.s_ready  <= 1'b1;
         bus.mem_we   <= '0;
         bus.mem_addr <= '0;
         bus.cpu_run  <= 1'b0;
         bus.last_pc  <= '0;
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         bus.s_ready <= s_ready_d;
         bus.cpu_run <= cpu_run_d;
         bus.done    <= done_d;
         drain_cnt   <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;

         if (accept_c) begin
            lat_last     <= bus.s_last;
            lat_ovf      <= ovf_c;
            bus.mem_addr <= base[ADDR_W-1:0];
            if (ovf_c) begin
               // word is swallowed: no strobes, base holds, segment carries on
               bus.mem_we <= '0;
               bus.err    <= 1'b1;
            end else begin
               bus.mem_we <= NUM_MEMS'(1) << sel;
               if (sel == '0) bus.last_pc <= base[ADDR_W-1:0];
            end
         end else if (ser_last_c) begin
            bus.mem_we <= '0;
            if (lat_last) begin
               if (sel != LAST_SEL) begin
                  sel  <= sel + SW'(1);
                  base <= '0;
               end
            end else if (!lat_ovf) begin
               base <= base + BW'(BYTES);
            end
         end else if (ser_busy) begin
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mips_mem_loader.sv
// Bench for mips_mem_loader: a default little-endian instance (32-bit words,
// 2 memories, DRAIN_CYC=2) and a small big-endian instance (16-bit words,
// 8-byte memories, 3 memories, DRAIN_CYC=0) checked against memory images
// computed from the loaded word lists.
module tb_mips_mem_loader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mips_mem_loader_if #(.WORD_W(32), .ADDR_W(10), .NUM_MEMS(2)) ia ();
   mips_mem_loader_if #(.WORD_W(16), .ADDR_W(3),  .NUM_MEMS(3)) ib ();

   mips_mem_loader #(.WORD_W(32), .ADDR_W(10), .NUM_MEMS(2), .BIG_ENDIAN(0), .DRAIN_CYC(2))
      dut_a (.clk(clk), .rst(rst), .bus(ia.master));
   mips_mem_loader #(.WORD_W(16), .ADDR_W(3), .NUM_MEMS(3), .BIG_ENDIAN(1), .DRAIN_CYC(0))
      dut_b (.clk(clk), .rst(rst), .bus(ib.master));

   int tests = 0;
   int fails = 0;

   // Word lists per memory
   int          na [2];
   logic [31:0] seg_a [2][8];
   int          nb [3];
   logic [15:0] seg_b [3][8];

   // Write capture
   logic [7:0] cap_a  [2][1024];
   int         wcnt_a [2][1024];
   int         tot_a, viol_a;
   logic [7:0] cap_b  [3][8];
   int         wcnt_b [3][8];
   int         tot_b, viol_b;

   always @(negedge clk) begin
      if (rst) begin
         for (int m = 0; m < 2; m++)
            for (int a = 0; a < 1024; a++) begin
               cap_a[m][a]  <= '0;
               wcnt_a[m][a] <= 0;
            end
         for (int m = 0; m < 3; m++)
            for (int a = 0; a < 8; a++) begin
               cap_b[m][a]  <= '0;
               wcnt_b[m][a] <= 0;
            end
         tot_a <= 0; viol_a <= 0; tot_b <= 0; viol_b <= 0;
      end else begin
         for (int m = 0; m < 2; m++)
            if (ia.mem_we[m]) begin
               cap_a[m][ia.mem_addr]  <= ia.mem_wdata;
               wcnt_a[m][ia.mem_addr] <= wcnt_a[m][ia.mem_addr] + 1;
            end
         for (int m = 0; m < 3; m++)
            if (ib.mem_we[m]) begin
               cap_b[m][ib.mem_addr]  <= ib.mem_wdata;
               wcnt_b[m][ib.mem_addr] <= wcnt_b[m][ib.mem_addr] + 1;
            end
         tot_a <= tot_a + $countones(ia.mem_we);
         tot_b <= tot_b + $countones(ib.mem_we);
         if ((ia.mem_we != '0 && ia.s_ready) || $countones(ia.mem_we) > 1) viol_a <= viol_a + 1;
         if ((ib.mem_we != '0 && ib.s_ready) || $countones(ib.mem_we) > 1) viol_b <= viol_b + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int min4(input int x);
      return (x > 4) ? 4 : x;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_reset_a(input string tag);
      check({tag, "_s_ready"},   64'(ia.s_ready),   64'd1);
      check({tag, "_mem_we"},    64'(ia.mem_we),    64'd0);
      check({tag, "_mem_addr"},  64'(ia.mem_addr),  64'd0);
      check({tag, "_mem_wdata"}, 64'(ia.mem_wdata), 64'd0);
      check({tag, "_cpu_run"},   64'(ia.cpu_run),   64'd0);
      check({tag, "_last_pc"},   64'(ia.last_pc),   64'd0);
      check({tag, "_done"},      64'(ia.done),      64'd0);
      check({tag, "_err"},       64'(ia.err),       64'd0);
   endtask

   // Present one word; returns at the negedge of the first write cycle.
   task automatic send_a(input logic [31:0] w, input logic l);
      int n;
      n = 0;
      ia.s_valid = 1'b1; ia.s_data = w; ia.s_last = l;
      while (ia.s_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      check("a_accept_timeout", 64'(n >= 100), 64'd0);
      @(posedge clk);
      #1 ia.s_valid = 1'b0; ia.s_data = 32'($urandom);
      @(negedge clk);
   endtask

   task automatic send_b(input logic [15:0] w, input logic l);
      int n;
      n = 0;
      ib.s_valid = 1'b1; ib.s_data = w; ib.s_last = l;
      while (ib.s_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      check("b_accept_timeout", 64'(n >= 100), 64'd0);
      @(posedge clk);
      #1 ib.s_valid = 1'b0; ib.s_data = 16'($urandom);
      @(negedge clk);
   endtask

   task automatic load_a();
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < na[m]; i++) send_a(seg_a[m][i], i == na[m] - 1);
   endtask

   task automatic load_b();
      for (int m = 0; m < 3; m++)
         for (int i = 0; i < nb[m]; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_b(seg_b[m][i], i == nb[m] - 1);
         end
   endtask

   task automatic wait_run_a();
      int n;
      n = 0;
      while (ia.cpu_run !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("a_run_timeout", 64'(n >= 200), 64'd0);
   endtask

   task automatic wait_run_b();
      int n;
      n = 0;
      while (ib.cpu_run !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("b_run_timeout", 64'(n >= 200), 64'd0);
   endtask

   // Little-endian image: address 4i+k holds bits [8k+7:8k] of word i
   task automatic check_mem_a();
      int exp_tot;
      exp_tot = 0;
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < na[m]; i++)
            for (int k = 0; k < 4; k++) begin
               check($sformatf("a_mem%0d_byte%0d", m, 4 * i + k),
                     64'(cap_a[m][4 * i + k]), 64'(8'(seg_a[m][i] >> (8 * k))));
               check($sformatf("a_mem%0d_wcnt%0d", m, 4 * i + k),
                     64'(wcnt_a[m][4 * i + k]), 64'd1);
               exp_tot++;
            end
      check("a_total_writes", 64'(tot_a), 64'(exp_tot));
      check("a_strobe_rules", 64'(viol_a), 64'd0);
      check("a_last_pc", 64'(ia.last_pc), 64'(4 * (na[0] - 1)));
   endtask

   // Big-endian 16-bit image in 8-byte memories: only the first 4 words of a segment fit
   task automatic check_mem_b();
      int  exp_tot;
      logic exp_err;
      exp_tot = 0;
      exp_err = 1'b0;
      for (int m = 0; m < 3; m++) begin
         if (nb[m] > 4) exp_err = 1'b1;
         for (int i = 0; i < min4(nb[m]); i++)
            for (int k = 0; k < 2; k++) begin
               check($sformatf("b_mem%0d_byte%0d", m, 2 * i + k),
                     64'(cap_b[m][2 * i + k]), 64'(8'(seg_b[m][i] >> (8 * (1 - k)))));
               check($sformatf("b_mem%0d_wcnt%0d", m, 2 * i + k),
                     64'(wcnt_b[m][2 * i + k]), 64'd1);
               exp_tot++;
            end
      end
      check("b_total_writes", 64'(tot_b), 64'(exp_tot));
      check("b_strobe_rules", 64'(viol_b), 64'd0);
      check("b_err", 64'(ib.err), 64'(exp_err));
      check("b_last_pc", 64'(ib.last_pc), 64'(2 * (min4(nb[0]) - 1)));
   endtask

   initial begin
      logic [7:0] exp_bytes [4];
      rst = 1'b1;
      ia.s_valid = 1'b0; ia.s_data = '0; ia.s_last = 1'b0; ia.pc = '0;
      ib.s_valid = 1'b0; ib.s_data = '0; ib.s_last = 1'b0; ib.pc = 3'd7;
      repeat (3) @(negedge clk);
      chk_reset_a("rst0");
      check("rst0_b_s_ready", 64'(ib.s_ready), 64'd1);
      check("rst0_b_mem_we",  64'(ib.mem_we),  64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed program load with cycle-level checks of the first word
      na[0] = 2; na[1] = 1;
      seg_a[0][0] = 32'h8C010000; seg_a[0][1] = 32'h20020005; seg_a[1][0] = 32'h0000002A;
      exp_bytes[0] = 8'h00; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h01; exp_bytes[3] = 8'h8C;
      send_a(seg_a[0][0], 1'b0);
      check("w0_s_ready_low", 64'(ia.s_ready), 64'd0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("w0_we_%0d", k),    64'(ia.mem_we),    64'd1);
         check($sformatf("w0_addr_%0d", k),  64'(ia.mem_addr),  64'(k));
         check($sformatf("w0_wdata_%0d", k), 64'(ia.mem_wdata), 64'(exp_bytes[k]));
         @(negedge clk);
      end
      check("w0_gap_we",      64'(ia.mem_we),  64'd0);
      check("w0_gap_s_ready", 64'(ia.s_ready), 64'd1);
      send_a(seg_a[0][1], 1'b1);
      send_a(seg_a[1][0], 1'b1);
      repeat (3) @(negedge clk);
      check("dm3_we",      64'(ia.mem_we),   64'd2);
      check("dm3_addr",    64'(ia.mem_addr), 64'd3);
      check("dm3_cpu_run", 64'(ia.cpu_run),  64'd0);
      @(negedge clk);
      check("run_cpu_run", 64'(ia.cpu_run), 64'd1);
      check("run_we",      64'(ia.mem_we),  64'd0);
      check("run_s_ready", 64'(ia.s_ready), 64'd0);
      check_mem_a();
      check("a_err_clean", 64'(ia.err), 64'd0);

      // pc wandering away from last_pc never finishes
      for (int i = 0; i < 10; i++) begin
         ia.pc = (i % 2 == 0) ? 10'd0 : 10'd8;
         @(negedge clk);
      end
      check("nomatch_done",    64'(ia.done),    64'd0);
      check("nomatch_cpu_run", 64'(ia.cpu_run), 64'd1);
      ia.pc = 10'd4;                    // match cycle t
      @(negedge clk); ia.pc = 10'd8;
      check("done_t1", 64'(ia.done), 64'd0);
      @(negedge clk);
      check("done_t2", 64'(ia.done), 64'd0);
      @(negedge clk);
      check("done_t3", 64'(ia.done), 64'd1);
      repeat (3) @(negedge clk);
      check("done_sticky",    64'(ia.done),    64'd1);
      check("done_cpu_run",   64'(ia.cpu_run), 64'd1);

      // Random programs, pc parked on the final instruction (match in first RUN cycle)
      for (int it = 0; it < 3; it++) begin
         na[0] = $urandom_range(1, 6); na[1] = $urandom_range(1, 6);
         for (int m = 0; m < 2; m++)
            for (int i = 0; i < 8; i++) seg_a[m][i] = $urandom;
         ia.pc = 10'(4 * (na[0] - 1));
         do_reset();
         load_a();
         wait_run_a();
         check("rnd_a_done_c0", 64'(ia.done), 64'd0);
         repeat (2) @(negedge clk);
         check("rnd_a_done_c2", 64'(ia.done), 64'd0);
         @(negedge clk);
         check("rnd_a_done_c3", 64'(ia.done), 64'd1);
         check_mem_a();
         check("rnd_a_err", 64'(ia.err), 64'd0);
      end

      // Reset during the second byte of a word, then a fresh load
      ia.pc = 10'd1;
      do_reset();
      send_a(32'hDEADBEEF, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk_reset_a("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      na[0] = 1; na[1] = 1;
      seg_a[0][0] = 32'h01020304; seg_a[1][0] = 32'hA5A5_0F0F;
      send_a(seg_a[0][0], 1'b1);
      check("fresh_we",    64'(ia.mem_we),    64'd1);
      check("fresh_addr",  64'(ia.mem_addr),  64'd0);
      check("fresh_wdata", 64'(ia.mem_wdata), 64'h04);
      send_a(seg_a[1][0], 1'b1);
      wait_run_a();
      check_mem_a();

      // Small big-endian instance: overflow, three segments, gapped valid
      for (int it = 0; it < 4; it++) begin
         nb[0] = (it == 0) ? 6 : $urandom_range(1, 6);
         nb[1] = $urandom_range(1, 5);
         nb[2] = $urandom_range(1, 5);
         for (int m = 0; m < 3; m++)
            for (int i = 0; i < 8; i++) seg_b[m][i] = 16'($urandom);
         ib.pc = 3'd7;
         do_reset();
         load_b();
         wait_run_b();
         @(negedge clk);
         check_mem_b();
         check("rnd_b_done_pre", 64'(ib.done), 64'd0);
         ib.pc = 3'(2 * (min4(nb[0]) - 1));
         @(negedge clk);
         check("rnd_b_done_post", 64'(ib.done), 64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
